// File: rtl/dapuf_eval_ctrl.sv
// Evaluation sequencer for a double-arbiter PUF: drives challenge and excite lines,
// synchronises the arbiter response, and majority-votes NUM_EVAL samples per challenge.
module dapuf_eval_ctrl #(
    parameter int CHAL_W     = 40,
    parameter int SETTLE_CYC = 8,
    parameter int NUM_EVAL   = 5,
    localparam int CNT_W     = $clog2(NUM_EVAL + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CHAL_W-1:0] challenge_in,
    output logic              busy,
    output logic              done,
    output logic              response_out,
    output logic [CNT_W-1:0]  ones_count,
    output logic              unstable,
    output logic [CHAL_W-1:0] puf_challenge,
    output logic              puf_exciteL,
    output logic              puf_exciteR,
    input  logic              puf_response
);

    localparam int PH_W = $clog2(SETTLE_CYC);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] EVAL_LAST = CNT_W'(NUM_EVAL);
    localparam logic [CNT_W-1:0] HALF      = CNT_W'(NUM_EVAL / 2);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [PH_W-1:0]   phase_r;
    logic [CNT_W-1:0]  eval_r;
    logic [CNT_W-1:0]  ones_r;
    logic              sync1_r;
    logic              sync2_r;
    logic              resp_r;
    logic              unst_r;
    logic [CHAL_W-1:0] chal_r;
    logic              excite_r;
    logic              busy_r;
    logic              done_r;
    logic              phase_last_s;
    logic              accept_s;

    // Next-state logic; every phase state leaves on its last phase cycle.
    always_comb begin
        state_s      = state_r;
        phase_last_s = (phase_r == PH_LAST);
        accept_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s  = LOAD;
                    accept_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (phase_last_s) state_s = HIGH;
                else              state_s = LOAD;
            end
            HIGH: begin
                if (phase_last_s) state_s = LOW;
                else              state_s = HIGH;
            end
            LOW: begin
                if (phase_last_s) begin
                    if (eval_r < EVAL_LAST) state_s = HIGH;
                    else                    state_s = DONE;
                end else begin
                    state_s = LOW;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, phase counter and evaluation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            phase_r <= '0;
            eval_r  <= '0;
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || (state_r == IDLE) || (state_r == DONE)) begin
                phase_r <= '0;
            end else begin
                phase_r <= phase_r + PH_W'(1);
            end
            if (accept_s) begin
                eval_r <= '0;
            end else if ((state_r == HIGH) && (state_s == LOW)) begin
                eval_r <= eval_r + CNT_W'(1);
            end
        end
    end

    // Two-flop synchroniser for the asynchronous arbiter response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= puf_response;
            sync2_r <= sync1_r;
        end
    end

    // Sample accumulation and result registers; results hold until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_r <= '0;
            resp_r <= 1'b0;
            unst_r <= 1'b0;
            chal_r <= '0;
        end else begin
            if (accept_s) begin
                ones_r <= '0;
                chal_r <= challenge_in;
            end else if ((state_r == HIGH) && (state_s == LOW)) begin
                ones_r <= ones_r + CNT_W'(sync2_r);
            end
            if ((state_s == DONE) && (state_r != DONE)) begin
                resp_r <= (ones_r > HALF);
                unst_r <= (ones_r != '0) && (ones_r != EVAL_LAST);
            end
        end
    end

    // Registered control outputs decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            excite_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            excite_r <= (state_s == HIGH);
            busy_r   <= (state_s == LOAD) || (state_s == HIGH) || (state_s == LOW);
            done_r   <= (state_s == DONE);
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign response_out  = resp_r;
    assign ones_count    = ones_r;
    assign unstable      = unst_r;
    assign puf_challenge = chal_r;
    assign puf_exciteL   = excite_r;
    assign puf_exciteR   = excite_r;

endmodule

// File: tb/tb_dapuf_eval_ctrl.sv
// Scoreboard bench for dapuf_eval_ctrl: directed challenges with hand-computed votes,
// one instance at SETTLE_CYC=4/NUM_EVAL=3 and one at SETTLE_CYC=3/NUM_EVAL=1.
module tb_dapuf_eval_ctrl;

    typedef struct {
        longint done_cyc;
        int     ones;
        bit     resp;
        bit     unst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [39:0] challenge_in = 40'h0;
    logic        busy, done, response_out, unstable, ex_l, ex_r;
    logic [1:0]  ones_count;
    logic [39:0] puf_challenge;
    logic        puf_response = 1'b0;

    logic        start1 = 1'b0;
    logic [39:0] challenge1 = 40'h0;
    logic        busy1, done1, resp1_out, unst1, ex1_l, ex1_r;
    logic [0:0]  ones1;
    logic [39:0] chal1_out;
    logic        puf_resp1 = 1'b0;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   sb[$];
    exp_t   sb1[$];
    bit     pat_q[$];
    bit     glitch = 1'b0;
    bit     cur = 1'b1;
    int     hc = 0;
    bit     prev_resp = 1'b0;

    dapuf_eval_ctrl #(.CHAL_W(40), .SETTLE_CYC(4), .NUM_EVAL(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge_in(challenge_in),
        .busy(busy), .done(done), .response_out(response_out), .ones_count(ones_count),
        .unstable(unstable), .puf_challenge(puf_challenge), .puf_exciteL(ex_l),
        .puf_exciteR(ex_r), .puf_response(puf_response)
    );

    dapuf_eval_ctrl #(.CHAL_W(40), .SETTLE_CYC(3), .NUM_EVAL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .challenge_in(challenge1),
        .busy(busy1), .done(done1), .response_out(resp1_out), .ones_count(ones1),
        .unstable(unst1), .puf_challenge(chal1_out), .puf_exciteL(ex1_l),
        .puf_exciteR(ex1_r), .puf_response(puf_resp1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response driver: per-evaluation value from pat_q, optional glitches away from the sample window.
    always @(negedge clk) begin
        if (!rst_n) begin
            hc = 0;
        end else if (ex_l) begin
            hc++;
            if (hc == 1) cur = (pat_q.size() > 0) ? pat_q.pop_front() : 1'b1;
            puf_response = (glitch && hc < 2) ? ~cur : cur;
        end else begin
            hc = 0;
            if (glitch) puf_response = ~puf_response;
        end
    end

    // Monitor for the main instance: excite waveform and result scoreboard.
    int     rises = 0;
    int     hi_len = 0;
    bit     prev_ex = 1'b0;
    logic [39:0] prev_chal = 40'h0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rises = 0; hi_len = 0; prev_ex = 1'b0;
        end else begin
            chk("exciteR_eq_exciteL", ex_r, ex_l);
            if (ex_l && !prev_ex) rises++;
            if (ex_l) begin
                hi_len++;
                if (prev_ex) chk("chal_stable_excite", puf_challenge, prev_chal);
            end else if (prev_ex) begin
                chk("pulse_len", hi_len, 4);
                hi_len = 0;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_done: got done=1 expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("done_cycle", cyc, e.done_cyc);
                    chk("ones_count", ones_count, e.ones);
                    chk("response_out", response_out, e.resp);
                    chk("unstable", unstable, e.unst);
                    chk("busy_in_done", busy, 0);
                    chk("excite_rises", rises, 3);
                end
                rises = 0;
            end
            prev_ex = ex_l;
            prev_chal = puf_challenge;
        end
    end

    // Monitor for the single-evaluation instance.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done1) begin
            if (sb1.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_done1: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                e = sb1.pop_front();
                chk("done1_cycle", cyc, e.done_cyc);
                chk("ones1", ones1, e.ones);
                chk("resp1", resp1_out, e.resp);
                chk("unst1", unst1, e.unst);
            end
        end
    end

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_ex(input bit v);
        int n = 0;
        while (ex_l !== v && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("excite_timeout", ex_l, v);
    endtask

    task automatic push_exp(input longint t, input int o, input bit r, input bit u);
        exp_t e;
        e.done_cyc = t; e.ones = o; e.resp = r; e.unst = u;
        sb.push_back(e);
    endtask

    task automatic run(input logic [39:0] chal, input bit [2:0] pat, input bit gl,
                       input int e_ones, input bit e_resp, input bit e_unst, input bit poke);
        longint t;
        @(negedge clk);
        glitch = gl;
        for (int i = 2; i >= 0; i--) pat_q.push_back(pat[i]);
        start = 1'b1;
        challenge_in = chal;
        t = cyc + 1;
        push_exp(t + 28, e_ones, e_resp, e_unst);
        @(negedge clk);
        start = 1'b0;
        challenge_in = ~chal;
        chk("chal_latched", puf_challenge, chal);
        chk("ones_cleared", ones_count, 0);
        chk("resp_held", response_out, prev_resp);
        chk("busy_after_accept", busy, 1);
        if (poke) begin
            repeat (6) @(negedge clk);
            start = 1'b1;
            challenge_in = 40'hDEADBEEF11;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("chal_ignored", puf_challenge, chal);
        end
        wait_done();
        prev_resp = e_resp;
    endtask

    task automatic run1(input logic [39:0] chal, input bit r, input int e_ones,
                        input bit e_resp, input bit e_unst);
        exp_t e;
        int n = 0;
        @(negedge clk);
        puf_resp1 = r;
        start1 = 1'b1;
        challenge1 = chal;
        e.done_cyc = cyc + 1 + 9; e.ones = e_ones; e.resp = e_resp; e.unst = e_unst;
        sb1.push_back(e);
        @(negedge clk);
        start1 = 1'b0;
        while (done1 !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("done1_timeout", 0, 1);
    endtask

    initial begin
        longint t;
        int n;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ones", ones_count, 0);
        chk("rst_resp", response_out, 0);
        chk("rst_unst", unstable, 0);
        chk("rst_excite", ex_l, 0);
        chk("rst_chal", puf_challenge, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset during the second HIGH phase: everything drops without a clock edge.
        @(negedge clk);
        start = 1'b1;
        challenge_in = 40'hA5A5A5A5A5;
        @(negedge clk);
        start = 1'b0;
        wait_ex(1'b1);
        wait_ex(1'b0);
        wait_ex(1'b1);
        chk("pre_rst_ones", ones_count, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_exciteL", ex_l, 0);
        chk("arst_exciteR", ex_r, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_ones", ones_count, 0);
        chk("arst_chal", puf_challenge, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prev_resp = 1'b0;

        run(40'hA5A5A5A5A5, 3'b111, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        run(40'h123456789A, 3'b101, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        run(40'h0F0F0F0F0F, 3'b001, 1'b1, 1, 1'b0, 1'b1, 1'b0);
        run(40'hFFFFFFFFFF, 3'b000, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        run(40'h0000000001, 3'b110, 1'b1, 2, 1'b1, 1'b1, 1'b0);
        run(40'hCAFEBABE00, 3'b011, 1'b0, 2, 1'b1, 1'b1, 1'b1);

        // start held high: second run accepted in the IDLE cycle right after done.
        @(negedge clk);
        glitch = 1'b0;
        pat_q.push_back(1'b1); pat_q.push_back(1'b1); pat_q.push_back(1'b1);
        pat_q.push_back(1'b0); pat_q.push_back(1'b1); pat_q.push_back(1'b0);
        start = 1'b1;
        challenge_in = 40'h1111111111;
        t = cyc + 1;
        push_exp(t + 28, 3, 1'b1, 1'b0);
        push_exp(t + 30 + 28, 1, 1'b0, 1'b1);
        n = 0;
        while (cyc < t + 30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("held_reaccept_busy", busy, 1);
        chk("held_ones_cleared", ones_count, 0);
        wait_done();

        run1(40'h00000000AA, 1'b1, 1, 1'b1, 1'b0);
        run1(40'h0000000055, 1'b0, 0, 1'b0, 1'b0);

        repeat (40) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
